// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: two-entry skid buffer sitting between fetch (IF) and decode (ID).
// Holds {PC, PC+4, instruction}. The main entry drives id_*; the skid entry catches
// the one beat that fetch may push while decode stalls. if_ready depends on state only.
// Optional feature macro: IFID_PERF_CNT_EN adds stall_cnt / flush_cnt event counters.
module if_id_skid_buffer #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               if_valid,
   output logic               if_ready,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic [ADDR_W-1:0]  if_pcplus4,
   input  logic [INSTR_W-1:0] if_instruction,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pcplus4,
   output logic [INSTR_W-1:0] id_instruction
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
`endif
);

   // Occupancy: StEmpty = no beat, StOne = main only, StFull = main + skid.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e               r_state_q;
   state_e               w_state_d;

   logic [ADDR_W-1:0]    r_main_pc;
   logic [ADDR_W-1:0]    r_main_pcplus4;
   logic [INSTR_W-1:0]   r_main_instr;
   logic [ADDR_W-1:0]    r_skid_pc;
   logic [ADDR_W-1:0]    r_skid_pcplus4;
   logic [INSTR_W-1:0]   r_skid_instr;

   logic                 w_in;
   logic                 w_out;
   logic                 w_load_main_in;
   logic                 w_load_main_skid;
   logic                 w_load_skid;

   // Handshake flags; ready/valid are pure functions of state so there is no
   // combinational path from id_ready back to if_ready.
   assign if_ready = (r_state_q != StFull);
   assign id_valid = (r_state_q != StEmpty);
   assign w_in     = if_valid & if_ready;
   assign w_out    = id_valid & id_ready;

   assign id_pc          = r_main_pc;
   assign id_pcplus4     = r_main_pcplus4;
   assign id_instruction = r_main_instr;

   // Next-state and entry-load decode; flush overrides everything and blocks all loads.
   always_comb begin
      w_state_d        = r_state_q;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state_q)
         StEmpty: begin
            if (w_in) begin
               w_state_d      = StOne;
               w_load_main_in = 1'b1;
            end
         end
         StOne: begin
            if (w_in && !w_out) begin
               w_state_d   = StFull;
               w_load_skid = 1'b1;
            end else if (w_out && !w_in) begin
               w_state_d = StEmpty;
            end else if (w_in && w_out) begin
               w_state_d      = StOne;
               w_load_main_in = 1'b1;
            end
         end
         StFull: begin
            // if_ready is low here, so only the drain side can move.
            if (w_out) begin
               w_state_d        = StOne;
               w_load_main_skid = 1'b1;
            end
         end
         default: begin
            w_state_d = StEmpty;
         end
      endcase
      if (flush) begin
         w_state_d        = StEmpty;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   // State register; reset takes priority over flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q <= StEmpty;
      end else begin
         r_state_q <= w_state_d;
      end
   end

   // Main entry: loaded from fetch or promoted from skid; holds otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_main_pc      <= '0;
         r_main_pcplus4 <= '0;
         r_main_instr   <= '0;
      end else if (w_load_main_in) begin
         r_main_pc      <= if_pc;
         r_main_pcplus4 <= if_pcplus4;
         r_main_instr   <= if_instruction;
      end else if (w_load_main_skid) begin
         r_main_pc      <= r_skid_pc;
         r_main_pcplus4 <= r_skid_pcplus4;
         r_main_instr   <= r_skid_instr;
      end
   end

   // Skid entry: captures the younger beat while the main entry is stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_skid_pc      <= '0;
         r_skid_pcplus4 <= '0;
         r_skid_instr   <= '0;
      end else if (w_load_skid) begin
         r_skid_pc      <= if_pc;
         r_skid_pcplus4 <= if_pcplus4;
         r_skid_instr   <= if_instruction;
      end
   end

`ifdef IFID_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // Event counters: fetch-blocked cycles and flush cycles; flush does not clear them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (if_valid && !if_ready) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (flush) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb_if_id_skid_buffer: directed vector table plus hand-written ordering and
// counter sequences for if_id_skid_buffer.
module tb_if_id_skid_buffer;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        if_valid;
   logic        if_ready;
   logic [63:0] if_pc;
   logic [63:0] if_pcplus4;
   logic [31:0] if_instruction;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [63:0] id_pcplus4;
   logic [31:0] id_instruction;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   if_id_skid_buffer #(
      .ADDR_W  (64),
      .INSTR_W (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_pcplus4     (if_pcplus4),
      .if_instruction (if_instruction),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_pcplus4     (id_pcplus4),
      .id_instruction (id_instruction)
`ifdef IFID_PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // rst/fl/iv/ir/pc are inputs applied before an edge; the rest is expected after it.
   // ez: payload expected to be the all-zero reset value.
   typedef struct {
      logic        rst;
      logic        fl;
      logic        iv;
      logic        ir;
      logic [63:0] pc;
      logic        ev;
      logic        er;
      logic [63:0] epc;
      logic        ez;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                               input logic ir, input logic [63:0] pc, input logic ev,
                               input logic er, input logic [63:0] epc, input logic ez);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ir = ir; v.pc = pc;
      v.ev = ev; v.er = er; v.epc = epc; v.ez = ez;
      return v;
   endfunction

   function automatic logic [31:0] instr_of(input logic [63:0] pc);
      logic [31:0] lo;
      lo = pc[31:0];
      return 32'h1300_0013 ^ lo;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv, input logic ir,
                        input logic [63:0] pc);
      reset          = rst;
      flush          = fl;
      if_valid       = iv;
      id_ready       = ir;
      if_pc          = pc;
      if_pcplus4     = pc + 64'd4;
      if_instruction = instr_of(pc);
   endtask

   task automatic step(input logic rst, input logic fl, input logic iv, input logic ir,
                       input logic [63:0] pc);
      drive(rst, fl, iv, ir, pc);
      @(posedge clk);
      #1;
   endtask

   logic [63:0] e_p4;
   logic [31:0] e_in;
   logic [63:0] f_pc;
   logic [63:0] exp_pc;
   logic        w_in_s;
   logic        w_out_s;
   int          n_in;
   int          n_out;

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);

      // Reset
      vecs.push_back(mk(1, 0, 0, 0, 64'h0,   0, 1, 64'h0,   1));
      // Stream 0x0..0xC at full rate, then drain
      vecs.push_back(mk(0, 0, 1, 1, 64'h0,   1, 1, 64'h0,   0));
      vecs.push_back(mk(0, 0, 1, 1, 64'h4,   1, 1, 64'h4,   0));
      vecs.push_back(mk(0, 0, 1, 1, 64'h8,   1, 1, 64'h8,   0));
      vecs.push_back(mk(0, 0, 1, 1, 64'hC,   1, 1, 64'hC,   0));
      vecs.push_back(mk(0, 0, 0, 1, 64'hC,   0, 1, 64'hC,   0));
      // Decode stall: 0x14 into skid, 0x18 held by fetch, then in-order drain
      vecs.push_back(mk(0, 0, 1, 0, 64'h10,  1, 1, 64'h10,  0));
      vecs.push_back(mk(0, 0, 1, 0, 64'h14,  1, 0, 64'h10,  0));
      vecs.push_back(mk(0, 0, 1, 0, 64'h18,  1, 0, 64'h10,  0));
      vecs.push_back(mk(0, 0, 1, 0, 64'h18,  1, 0, 64'h10,  0));
      vecs.push_back(mk(0, 0, 1, 1, 64'h18,  1, 1, 64'h14,  0));
      vecs.push_back(mk(0, 0, 1, 1, 64'h18,  1, 1, 64'h18,  0));
      vecs.push_back(mk(0, 0, 0, 1, 64'h18,  0, 1, 64'h18,  0));
      // Flush while full with 0x28 offered; payload holds, 0x100 follows
      vecs.push_back(mk(0, 0, 1, 0, 64'h20,  1, 1, 64'h20,  0));
      vecs.push_back(mk(0, 0, 1, 0, 64'h24,  1, 0, 64'h20,  0));
      vecs.push_back(mk(0, 1, 1, 0, 64'h28,  0, 1, 64'h20,  0));
      vecs.push_back(mk(0, 0, 1, 1, 64'h100, 1, 1, 64'h100, 0));
      vecs.push_back(mk(0, 0, 0, 1, 64'h100, 0, 1, 64'h100, 0));
      // Flush when empty / when one with in&out: offered beat dropped
      vecs.push_back(mk(0, 1, 1, 1, 64'h104, 0, 1, 64'h100, 0));
      vecs.push_back(mk(0, 0, 1, 0, 64'h108, 1, 1, 64'h108, 0));
      vecs.push_back(mk(0, 1, 1, 1, 64'h10C, 0, 1, 64'h108, 0));
      // Reset (with flush) while full clears everything
      vecs.push_back(mk(0, 0, 1, 0, 64'h30,  1, 1, 64'h30,  0));
      vecs.push_back(mk(0, 0, 1, 0, 64'h34,  1, 0, 64'h30,  0));
      vecs.push_back(mk(1, 1, 1, 1, 64'h38,  0, 1, 64'h0,   1));
      vecs.push_back(mk(0, 0, 0, 1, 64'h0,   0, 1, 64'h0,   1));
      // Simultaneous in&out while one
      vecs.push_back(mk(0, 0, 1, 0, 64'h40,  1, 1, 64'h40,  0));
      vecs.push_back(mk(0, 0, 1, 1, 64'h44,  1, 1, 64'h44,  0));
      vecs.push_back(mk(0, 0, 0, 1, 64'h44,  0, 1, 64'h44,  0));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ir, vecs[i].pc);
         e_p4 = vecs[i].ez ? 64'd0 : vecs[i].epc + 64'd4;
         e_in = vecs[i].ez ? 32'd0 : instr_of(vecs[i].epc);
         check($sformatf("v%0d id_valid", i), 64'(id_valid), 64'(vecs[i].ev));
         check($sformatf("v%0d if_ready", i), 64'(if_ready), 64'(vecs[i].er));
         check($sformatf("v%0d id_pc", i), id_pc, vecs[i].ez ? 64'd0 : vecs[i].epc);
         check($sformatf("v%0d id_pcplus4", i), id_pcplus4, e_p4);
         check($sformatf("v%0d id_instr", i), 64'(id_instruction), 64'(e_in));
      end

      // Ordering: fetch streams sequential PCs, decode stalls one cycle in three.
      f_pc   = 64'h200;
      exp_pc = 64'h200;
      n_in   = 0;
      n_out  = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b0, 1'b1, (i % 3) != 2, f_pc);
         w_in_s  = if_valid && if_ready;
         w_out_s = id_valid && id_ready;
         if (w_out_s) begin
            check($sformatf("order pop %0d", n_out), id_pc, exp_pc);
            exp_pc = exp_pc + 64'd4;
            n_out++;
         end
         @(posedge clk);
         #1;
         if (w_in_s) begin
            f_pc = f_pc + 64'd4;
            n_in++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, f_pc);
         if (id_valid) begin
            check($sformatf("drain pop %0d", n_out), id_pc, exp_pc);
            exp_pc = exp_pc + 64'd4;
            n_out++;
         end
         @(posedge clk);
         #1;
      end
      check("order in==out", 64'(n_out), 64'(n_in));
      check("order drained", 64'(id_valid), 64'd0);

`ifdef IFID_PERF_CNT_EN
      step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
      check("cnt stall rst", 64'(stall_cnt), 64'd0);
      check("cnt flush rst", 64'(flush_cnt), 64'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 64'h50);
      step(1'b0, 1'b0, 1'b1, 1'b0, 64'h54);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 64'h58);
      end
      check("cnt stall 5", 64'(stall_cnt), 64'd5);
      check("cnt flush 0", 64'(flush_cnt), 64'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
      check("cnt stall kept", 64'(stall_cnt), 64'd5);
      check("cnt flush 2", 64'(flush_cnt), 64'd2);
      check("cnt flushed", 64'(id_valid), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
